wb_writeback_unit: RTL and testbench

- Writeback stage of the 32-bit pipelined processor.
- Accepts one retiring instruction per handshake from the MEM stage, waits for a data-memory response on loads, and drives the register file's single write port (write_reg, write_data, regwrite).
- Optionally bypasses the pending write onto the decode-stage read data, closing the read-after-write window of the combinational register-file read.

---
 rtl/wb_writeback_unit.sv | 117 +++++++++++
 tb/tb_wb_writeback_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_unit.sv
// Writeback stage: retires ALU results and load data into the register file's single write port.
// Optional decode read bypass is built when WB_BYPASS_EN is defined.
module wb_writeback_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              flush,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              regwrite,
  input  logic [ADDR_W-1:0] rf_rd1_idx,
  input  logic [ADDR_W-1:0] rf_rd2_idx,
  input  logic [DATA_W-1:0] rf_rd1_data,
  input  logic [DATA_W-1:0] rf_rd2_data,
  output logic [DATA_W-1:0] byp_rd1_data,
  output logic [DATA_W-1:0] byp_rd2_data,
  output logic [31:0]       retired
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StWaitMem = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic              pend_rw_q, pend_rw_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              regwrite_q, regwrite_d;
  logic [31:0]       retired_q, retired_d;
  logic              accept;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    pend_rd_d    = pend_rd_q;
    pend_rw_d    = pend_rw_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    regwrite_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_memtoreg) begin
            pend_rd_d = in_rd;
            pend_rw_d = in_regwrite;
            state_d   = StWaitMem;
          end else if (in_regwrite) begin
            write_reg_d  = in_rd;
            write_data_d = in_alu_result;
            regwrite_d   = 1'b1;
          end
        end
      end
      StWaitMem: begin
        // Flush wins over a response arriving at the same edge.
        if (flush) begin
          state_d = StIdle;
        end else if (dmem_rvalid) begin
          write_reg_d  = pend_rd_q;
          write_data_d = dmem_rdata;
          regwrite_d   = pend_rw_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    retired_d = retired_q + {31'd0, regwrite_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pend_rd_q    <= '0;
      pend_rw_q    <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      regwrite_q   <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_rd_q    <= pend_rd_d;
      pend_rw_q    <= pend_rw_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      regwrite_q   <= regwrite_d;
      retired_q    <= retired_d;
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign regwrite   = regwrite_q;
  assign retired    = retired_q;

`ifdef WB_BYPASS_EN
  assign byp_rd1_data = (regwrite_q && (rf_rd1_idx == write_reg_q)) ? write_data_q : rf_rd1_data;
  assign byp_rd2_data = (regwrite_q && (rf_rd2_idx == write_reg_q)) ? write_data_q : rf_rd2_data;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^{rf_rd1_idx, rf_rd2_idx};
  assign byp_rd1_data  = rf_rd1_data;
  assign byp_rd2_data  = rf_rd2_data;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed plus randomized bench for wb_writeback_unit with a transaction-level expectation model.
module tb_wb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic        in_memtoreg;
  logic        in_regwrite;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        flush;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regwrite;
  logic [4:0]  rf_rd1_idx, rf_rd2_idx;
  logic [31:0] rf_rd1_data, rf_rd2_data;
  logic [31:0] byp_rd1_data, byp_rd2_data;
  logic [31:0] retired;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Expected architectural view: count of writes and the write currently on the port.
  logic [31:0] exp_retired;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wdata;
  logic        exp_rw;

  wb_writeback_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_alu_result(in_alu_result),
    .in_memtoreg  (in_memtoreg),
    .in_regwrite  (in_regwrite),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .flush        (flush),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .regwrite     (regwrite),
    .rf_rd1_idx   (rf_rd1_idx),
    .rf_rd2_idx   (rf_rd2_idx),
    .rf_rd1_data  (rf_rd1_data),
    .rf_rd2_data  (rf_rd2_data),
    .byp_rd1_data (byp_rd1_data),
    .byp_rd2_data (byp_rd2_data),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_byp();
    logic [31:0] e1, e2;
    rf_rd1_idx  = ($urandom_range(0, 1) == 0) ? exp_wreg : 5'($urandom);
    rf_rd2_idx  = ($urandom_range(0, 1) == 0) ? exp_wreg : 5'($urandom);
    rf_rd1_data = $urandom;
    rf_rd2_data = $urandom;
    #1;
    e1 = rf_rd1_data;
    e2 = rf_rd2_data;
`ifdef WB_BYPASS_EN
    if (exp_rw && rf_rd1_idx == exp_wreg) e1 = exp_wdata;
    if (exp_rw && rf_rd2_idx == exp_wreg) e2 = exp_wdata;
`endif
    chk("byp_rd1", byp_rd1_data, e1);
    chk("byp_rd2", byp_rd2_data, e2);
  endtask

  task automatic idle_cycle();
    step();
    exp_rw = 1'b0;
    chk("idle_regwrite", 32'(regwrite), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_retired", retired, exp_retired);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] data, input logic rw,
                     input logic fl);
    in_valid = 1'b1; in_rd = rd; in_alu_result = data; in_memtoreg = 1'b0;
    in_regwrite = rw; flush = fl;
    step();
    in_valid = 1'b0; flush = 1'b0;
    exp_rw = rw;
    if (rw) begin
      exp_retired = exp_retired + 1;
      exp_wreg    = rd;
      exp_wdata   = data;
      chk("alu_write_reg", 32'(write_reg), 32'(exp_wreg));
      chk("alu_write_data", write_data, exp_wdata);
    end
    chk("alu_regwrite", 32'(regwrite), 32'(rw));
    chk("alu_retired", retired, exp_retired);
    chk("alu_in_ready", 32'(in_ready), 32'd1);
  endtask

  // mode 0: normal response, 1: flush with response at the same edge, 2: reset mid-wait
  task automatic load(input logic [4:0] rd, input logic rw, input int lat,
                      input logic [31:0] data, input int mode);
    in_valid = 1'b1; in_rd = rd; in_memtoreg = 1'b1; in_regwrite = rw;
    in_alu_result = $urandom;
    step();
    exp_rw = 1'b0;
    chk("ld_wait_in_ready", 32'(in_ready), 32'd0);
    chk("ld_wait_regwrite", 32'(regwrite), 32'd0);
    for (int i = 1; i < lat; i++) begin
      // Offered instructions must not be taken while waiting.
      in_valid = $urandom_range(0, 1); in_memtoreg = $urandom_range(0, 1);
      in_regwrite = 1'b1; in_alu_result = $urandom;
      dmem_rdata = $urandom;
      if (mode == 2 && i == lat / 2 + 1) begin
        reset = 1'b0;
        #1;
        exp_retired = '0; exp_wreg = '0; exp_wdata = '0;
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        step();
        dmem_rvalid = 1'b0;
        chk("rst_no_write", 32'(regwrite), 32'd0);
        chk("rst_idle_ready", 32'(in_ready), 32'd1);
        chk("rst_retired_after", retired, 32'd0);
        return;
      end
      step();
      chk("ld_wait_in_ready", 32'(in_ready), 32'd0);
      chk("ld_wait_regwrite", 32'(regwrite), 32'd0);
    end
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = data; flush = (mode == 1);
    step();
    dmem_rvalid = 1'b0; flush = 1'b0;
    if (mode == 0) begin
      exp_rw = rw;
      exp_wreg = rd;
      exp_wdata = data;
      if (rw) exp_retired = exp_retired + 1;
      chk("ld_write_reg", 32'(write_reg), 32'(exp_wreg));
      chk("ld_write_data", write_data, exp_wdata);
    end
    chk("ld_regwrite", 32'(regwrite), 32'(exp_rw));
    chk("ld_in_ready", 32'(in_ready), 32'd1);
    chk("ld_retired", retired, exp_retired);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_rd = '0; in_alu_result = '0; in_memtoreg = 1'b0;
    in_regwrite = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; flush = 1'b0;
    rf_rd1_idx = '0; rf_rd2_idx = '0; rf_rd1_data = '0; rf_rd2_data = '0;
    exp_retired = '0; exp_wreg = '0; exp_wdata = '0; exp_rw = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 5; i++) idle_cycle();
    chk("reset_write_reg", 32'(write_reg), 32'd0);
    chk("reset_write_data", write_data, 32'd0);

    alu(5'd3, 32'h0000_000A, 1'b1, 1'b0);
    idle_cycle();

    alu(5'd1, 32'h11, 1'b1, 1'b0);
    alu(5'd2, 32'h22, 1'b1, 1'b0);
    idle_cycle();

    load(5'd5, 1'b1, 3, 32'hDEAD_BEEF, 0);
    idle_cycle();
    load(5'd6, 1'b1, 3, 32'h6666_6666, 1);
    idle_cycle();
    load(5'd6, 1'b1, 4, 32'h7777_7777, 2);
    idle_cycle();

    // Response while idle must be ignored; rd 0 is an ordinary destination.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1;
    idle_cycle();
    dmem_rvalid = 1'b0;
    alu(5'd0, 32'hCAFE_0000, 1'b1, 1'b0);
    load(5'd9, 1'b0, 2, 32'h9999_9999, 0);

    // Bypass: directed rd=4 write with decode reading 4 and 7.
    alu(5'd4, 32'h1234, 1'b1, 1'b0);
    rf_rd1_idx = 5'd4; rf_rd2_idx = 5'd7; rf_rd1_data = '0; rf_rd2_data = 32'h5A5A_0007;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_dir_rd1", byp_rd1_data, 32'h1234);
`else
    chk("byp_dir_rd1", byp_rd1_data, 32'h0);
`endif
    chk("byp_dir_rd2", byp_rd2_data, 32'h5A5A_0007);
    idle_cycle();
    chk_byp();

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1: alu(5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom));
        2: load(5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(1, 4), $urandom, 0);
        3: load(5'($urandom), 1'b1, $urandom_range(1, 4), $urandom, 1);
        default: idle_cycle();
      endcase
      chk_byp();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
